// File: rtl/pixel_draw_pkg.sv
// Shared definitions for the pixel multiplexer and the object drawing FSMs
// that feed it: draw FSM states and default coordinate/colour widths.
package pixel_draw_pkg;

  localparam int DEF_X_W     = 8;
  localparam int DEF_Y_W     = 7;
  localparam int DEF_COLOR_W = 3;
  localparam int PIX_COUNT_W = 16;

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_SETUP = 2'd1,
    ST_PLOT  = 2'd2
  } draw_state_t;

endpackage

// File: rtl/pixel_draw_mux_rr_arbiter.sv
// Grant selection for the pixel multiplexer: fixed time slots (mode 0) or
// round-robin that skips idle channels (mode 1). Purely combinational.
module rr_arbiter #(
  parameter int N = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  input  logic          mode,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] next_ptr
);

  logic [PW-1:0] scan_idx;
  logic [PW-1:0] win_idx;
  logic          found;

  // (base + off) mod N without a divider; base < N and off < N always hold.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base,
                                             input int unsigned   off);
    logic [PW:0] sum;
    sum = {1'b0, base} + (PW+1)'(off);
    if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
    return sum[PW-1:0];
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    grant    = '0;
    next_ptr = ptr;
    scan_idx = ptr;
    win_idx  = ptr;
    found    = 1'b0;
    // NOTE: blocking assignments here, so the scan sees its own earlier
    // results within the same evaluation ('found' stops at the first hit).
    if (mode) begin
      for (int k = 0; k < N; k++) begin
        scan_idx = wrap_add(ptr, int'(k));
        if (!found && valid[scan_idx]) begin
          found   = 1'b1;
          win_idx = scan_idx;
        end
      end
    end else begin
      found = valid[ptr];
    end

    if (found) grant[win_idx] = 1'b1;

    // Slot mode advances every cycle it is consulted; round-robin only moves
    // past a winner so an idle scan keeps its priority position.
    if (mode) next_ptr = found ? wrap_add(win_idx, 1) : ptr;
    else      next_ptr = wrap_add(ptr, 1);
  end

endmodule

// File: rtl/pixel_draw_mux.sv
// Arbitrates NUM_CH pixel sources, registers the winner's x/y/colour and
// strobes ld after SETUP_CYCLES of stable data, for the VGA adapter.
module pixel_draw_mux
  import pixel_draw_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int X_W          = DEF_X_W,
  parameter int Y_W          = DEF_Y_W,
  parameter int COLOR_W      = DEF_COLOR_W,
  parameter int SETUP_CYCLES = 1,
  parameter int ARB_MODE     = 1
) (
  input  logic                        clk,
  input  logic                        reset_co,
  input  logic                        en,
  input  logic [NUM_CH-1:0]           req_valid,
  output logic [NUM_CH-1:0]           req_ready,
  input  logic [NUM_CH*X_W-1:0]       req_x,
  input  logic [NUM_CH*Y_W-1:0]       req_y,
  input  logic [NUM_CH*COLOR_W-1:0]   req_color,
  output logic [X_W-1:0]              x,
  output logic [Y_W-1:0]              y,
  output logic [COLOR_W-1:0]          color_f,
  output logic                        ld,
  output logic                        busy,
  output logic [PIX_COUNT_W-1:0]      pix_count
);

  localparam int         PW         = $clog2(NUM_CH);
  localparam logic [2:0] SETUP_LOAD = 3'(SETUP_CYCLES - 1);
  localparam logic       MODE_RR    = (ARB_MODE != 0);

  draw_state_t         state;
  logic [PW-1:0]       ptr;
  logic [PW-1:0]       next_ptr;
  logic [NUM_CH-1:0]   grant;
  logic [2:0]          setup_cnt;
  logic                arb_active;
  logic                xfer;
  logic [X_W-1:0]      sel_x;
  logic [Y_W-1:0]      sel_y;
  logic [COLOR_W-1:0]  sel_color;

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .valid    (req_valid),
    .ptr      (ptr),
    .mode     (MODE_RR),
    .grant    (grant),
    .next_ptr (next_ptr)
  );

  // Ready depends only on state, en, valid and ptr -- never on the payload.
  assign arb_active = (state == ST_ARB) && en;
  assign req_ready  = arb_active ? grant : '0;
  assign xfer       = |req_ready;

  always_comb begin
    sel_x     = '0;
    sel_y     = '0;
    sel_color = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) begin
        sel_x     = sel_x     | req_x[i*X_W +: X_W];
        sel_y     = sel_y     | req_y[i*Y_W +: Y_W];
        sel_color = sel_color | req_color[i*COLOR_W +: COLOR_W];
      end
    end
  end

  // NOTE: non-blocking assignments for all state so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset_co) begin
    if (reset_co) begin
      state     <= ST_ARB;
      ptr       <= '0;
      setup_cnt <= '0;
      x         <= '0;
      y         <= '0;
      color_f   <= '0;
      ld        <= 1'b0;
      busy      <= 1'b0;
      pix_count <= '0;
    end else begin
      ld <= 1'b0;
      case (state)
        ST_ARB: begin
          if (arb_active) ptr <= next_ptr;
          if (xfer) begin
            x         <= sel_x;
            y         <= sel_y;
            color_f   <= sel_color;
            setup_cnt <= SETUP_LOAD;
            busy      <= 1'b1;
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (setup_cnt == 3'd0) begin
            ld    <= 1'b1;
            state <= ST_PLOT;
          end else begin
            setup_cnt <= setup_cnt - 3'd1;
          end
        end
        ST_PLOT: begin
          pix_count <= pix_count + 16'd1;
          busy      <= 1'b0;
          state     <= ST_ARB;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_ARB;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_draw_mux.sv
// Self-checking bench: instance a (round-robin, setup 1) and instance b
// (time slots, setup 4) share stimulus and are compared to a cycle model.
module tb_pixel_draw_mux;

  localparam int N  = 4;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;

  logic             clk = 1'b0;
  logic             reset_co = 1'b1;
  logic             en = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N*XW-1:0]  req_x = '0;
  logic [N*YW-1:0]  req_y = '0;
  logic [N*CW-1:0]  req_color = '0;

  logic [N-1:0]  rdy  [2];
  logic [XW-1:0] ox   [2];
  logic [YW-1:0] oy   [2];
  logic [CW-1:0] oc   [2];
  logic          old  [2];
  logic          obusy[2];
  logic [15:0]   ocnt [2];

  pixel_draw_mux #(.NUM_CH(N), .X_W(XW), .Y_W(YW), .COLOR_W(CW),
                   .SETUP_CYCLES(1), .ARB_MODE(1)) dut_a (
    .clk(clk), .reset_co(reset_co), .en(en), .req_valid(req_valid),
    .req_ready(rdy[0]), .req_x(req_x), .req_y(req_y), .req_color(req_color),
    .x(ox[0]), .y(oy[0]), .color_f(oc[0]), .ld(old[0]), .busy(obusy[0]),
    .pix_count(ocnt[0])
  );

  pixel_draw_mux #(.NUM_CH(N), .X_W(XW), .Y_W(YW), .COLOR_W(CW),
                   .SETUP_CYCLES(4), .ARB_MODE(0)) dut_b (
    .clk(clk), .reset_co(reset_co), .en(en), .req_valid(req_valid),
    .req_ready(rdy[1]), .req_x(req_x), .req_y(req_y), .req_color(req_color),
    .x(ox[1]), .y(oy[1]), .color_f(oc[1]), .ld(old[1]), .busy(obusy[1]),
    .pix_count(ocnt[1])
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_wait counts cycles until the instance arbitrates again (0 = arbitrating);
  // the plot strobe belongs to the last of those cycles.
  int          m_ptr [2];
  int          m_wait[2];
  int          m_cnt [2];
  logic [XW-1:0] m_x [2];
  logic [YW-1:0] m_y [2];
  logic [CW-1:0] m_c [2];

  function automatic int mode_of(input int k); return (k == 0) ? 1 : 0; endfunction
  function automatic int setup_of(input int k); return (k == 0) ? 1 : 4; endfunction

  function automatic int model_grant(input int k);
    if (m_wait[k] != 0 || !en) return -1;
    if (mode_of(k) == 1) begin
      for (int j = 0; j < N; j++) begin
        int c = (m_ptr[k] + j) % N;
        if (req_valid[c]) return c;
      end
      return -1;
    end
    return req_valid[m_ptr[k]] ? m_ptr[k] : -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ptr[k] = 0; m_wait[k] = 0; m_cnt[k] = 0;
      m_x[k] = '0; m_y[k] = '0; m_c[k] = '0;
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      int g = model_grant(k);
      if (m_wait[k] > 0) begin
        if (m_wait[k] == 1) m_cnt[k] = (m_cnt[k] + 1) % 65536;
        m_wait[k]--;
      end else if (en) begin
        if (g >= 0) begin
          m_x[k] = req_x[g*XW +: XW];
          m_y[k] = req_y[g*YW +: YW];
          m_c[k] = req_color[g*CW +: CW];
          m_wait[k] = setup_of(k) + 1;
        end
        if (mode_of(k) == 0) m_ptr[k] = (m_ptr[k] + 1) % N;
        else if (g >= 0)     m_ptr[k] = (g + 1) % N;
      end
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < 2; k++) begin
      int g = model_grant(k);
      string s = (k == 0) ? "a" : "b";
      logic [N-1:0] er = (g >= 0) ? N'(1 << g) : '0;
      check({"ready_", s}, 32'(rdy[k]), 32'(er));
      check({"x_", s}, 32'(ox[k]), 32'(m_x[k]));
      check({"y_", s}, 32'(oy[k]), 32'(m_y[k]));
      check({"color_", s}, 32'(oc[k]), 32'(m_c[k]));
      check({"ld_", s}, 32'(old[k]), 32'(m_wait[k] == 1));
      check({"busy_", s}, 32'(obusy[k]), 32'(m_wait[k] > 0));
      check({"pix_count_", s}, 32'(ocnt[k]), 32'(m_cnt[k]));
    end
  endtask

  // ---------------- cycle helpers ----------------
  task automatic sample();
    @(negedge clk);
    check_model();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Called just after a rising edge; reset rises with no clock edge before the check.
  task automatic do_reset();
    req_valid = '0;
    reset_co  = 1'b1;
    #2;
    model_reset();
    check_model();
    @(posedge clk);
    #1;
    reset_co = 1'b0;
  endtask

  task automatic set_data(input int i, input int xv, input int yv, input int cv);
    req_x[i*XW +: XW]     = XW'(xv);
    req_y[i*YW +: YW]     = YW'(yv);
    req_color[i*CW +: CW] = CW'(cv);
  endtask

  typedef struct {
    logic [N-1:0] valid;
    logic         en;
    logic [N-1:0] rdy_a;
    logic         ld_a;
    logic [N-1:0] rdy_b;
    logic         ld_b;
  } vec_t;

  vec_t tbl[13];

  initial begin
    // All four sources valid continuously from reset.
    tbl[0]  = '{4'hF, 1'b1, 4'b0001, 1'b0, 4'b0001, 1'b0};
    tbl[1]  = '{4'hF, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[2]  = '{4'hF, 1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0};
    tbl[3]  = '{4'hF, 1'b1, 4'b0010, 1'b0, 4'b0000, 1'b0};
    tbl[4]  = '{4'hF, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[5]  = '{4'hF, 1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1};
    tbl[6]  = '{4'hF, 1'b1, 4'b0100, 1'b0, 4'b0010, 1'b0};
    tbl[7]  = '{4'hF, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[8]  = '{4'hF, 1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0};
    tbl[9]  = '{4'hF, 1'b1, 4'b1000, 1'b0, 4'b0000, 1'b0};
    tbl[10] = '{4'hF, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[11] = '{4'hF, 1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1};
    tbl[12] = '{4'hF, 1'b1, 4'b0001, 1'b0, 4'b0100, 1'b0};

    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Round-robin, only ch2 valid.
    set_data(2, 10, 20, 5);
    req_valid = 4'b0100;
    sample();
    check("t1_ready", 32'(rdy[0]), 32'b0100);
    advance();
    req_valid = '0;
    sample();
    check("t1_x", 32'(ox[0]), 32'd10);
    check("t1_y", 32'(oy[0]), 32'd20);
    check("t1_color", 32'(oc[0]), 32'd5);
    check("t1_ld_early", 32'(old[0]), 32'd0);
    advance();
    sample();
    check("t1_ld", 32'(old[0]), 32'd1);
    advance();
    sample();
    check("t1_count", 32'(ocnt[0]), 32'd1);
    advance();

    // Table: all valid, grant order and plot spacing for both instances.
    do_reset();
    for (int i = 0; i < N; i++) set_data(i, 16*i + 3, 8*i + 1, i + 2);
    foreach (tbl[i]) begin
      req_valid = tbl[i].valid;
      en        = tbl[i].en;
      sample();
      check($sformatf("tbl%0d_ready_a", i), 32'(rdy[0]), 32'(tbl[i].rdy_a));
      check($sformatf("tbl%0d_ld_a", i), 32'(old[0]), 32'(tbl[i].ld_a));
      check($sformatf("tbl%0d_ready_b", i), 32'(rdy[1]), 32'(tbl[i].rdy_b));
      check($sformatf("tbl%0d_ld_b", i), 32'(old[1]), 32'(tbl[i].ld_b));
      check($sformatf("tbl%0d_onehot", i), 32'($countones(rdy[0]) <= 1), 32'd1);
      advance();
    end

    // Time slots with only ch3 valid; then the 4-cycle setup hold on b.
    do_reset();
    set_data(3, 77, 55, 6);
    req_valid = 4'b1000;
    for (int c = 0; c < 4; c++) begin
      sample();
      check($sformatf("t3_ready_b_c%0d", c), 32'(rdy[1]), (c == 3) ? 32'b1000 : 32'd0);
      advance();
    end
    req_valid = '0;
    for (int c = 4; c < 10; c++) begin
      sample();
      check($sformatf("t3_x_b_c%0d", c), 32'(ox[1]), 32'd77);
      check($sformatf("t3_y_b_c%0d", c), 32'(oy[1]), 32'd55);
      check($sformatf("t3_ld_b_c%0d", c), 32'(old[1]), 32'(c == 8));
      advance();
    end

    // en dropped during SETUP: in-flight plot completes, no new ready.
    do_reset();
    set_data(1, 200, 100, 1);
    req_valid = 4'b0010;
    en = 1'b1;
    sample();
    check("t4_ready", 32'(rdy[0]), 32'b0010);
    advance();
    en = 1'b0;
    sample();
    check("t4_busy", 32'(obusy[0]), 32'd1);
    advance();
    sample();
    check("t4_ld", 32'(old[0]), 32'd1);
    advance();
    for (int c = 3; c < 6; c++) begin
      sample();
      check($sformatf("t4_noready_c%0d", c), 32'(rdy[0]), 32'd0);
      advance();
    end
    en = 1'b1;
    sample();
    check("t4_ready_again", 32'(rdy[0]), 32'b0010);
    advance();
    req_valid = '0;
    for (int c = 0; c < 6; c++) begin sample(); advance(); end

    // Reset while in SETUP discards the pixel; next grant starts at ch0.
    do_reset();
    set_data(2, 99, 44, 7);
    req_valid = 4'b0100;
    sample();
    check("t5_ready", 32'(rdy[0]), 32'b0100);
    advance();
    req_valid = '0;
    reset_co = 1'b1;
    #2;
    check("t5_x", 32'(ox[0]), 32'd0);
    check("t5_busy", 32'(obusy[0]), 32'd0);
    check("t5_ld", 32'(old[0]), 32'd0);
    check("t5_count", 32'(ocnt[0]), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset_co = 1'b0;
    sample();
    check("t5_no_ld", 32'(old[0]), 32'd0);
    advance();
    req_valid = 4'hF;
    sample();
    check("t5_ready_ch0", 32'(rdy[0]), 32'b0001);
    advance();
    req_valid = '0;
    for (int c = 0; c < 6; c++) begin sample(); advance(); end

    // Randomised traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      for (int i = 0; i < N; i++) begin
        bit nv;
        nv = ($urandom_range(0, 3) != 0);
        if (nv && !req_valid[i])
          set_data(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                   int'($urandom_range(0, 7)));
        req_valid[i] = nv;
      end
      en = ($urandom_range(0, 7) != 0);
      sample();
      check("rand_onehot_a", 32'($countones(rdy[0]) <= 1), 32'd1);
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
